// File: rtl/systolic_array_ws_pkg.sv
// Shared types and constants for the weight-stationary systolic array.
// The top-level parameters default to the Def* values below.
package systolic_array_ws_pkg;

    localparam int DefBitSize        = 8;
    localparam int DefWeightBitSize  = 2;
    localparam int DefMWBitSize      = 8;
    localparam int DefNumOfInputs    = 2;
    localparam int DefNumOfNerves    = 3;
    localparam int DefDepthIn        = 2;

    typedef logic signed [DefBitSize-1:0]       act_t;
    typedef logic signed [DefWeightBitSize-1:0] weight_t;

    localparam int Latency = DefNumOfInputs + DefNumOfNerves - 1;

    function automatic int calcLatency(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_array_ws_pe.sv
// One processing element: a stationary weight, an activation passthrough,
// a wrapping multiply-accumulate, and a valid bit that travels with the data.
module systolic_pe
    import systolic_array_ws_pkg::*;
#(
    parameter int BitSize        = DefBitSize,
    parameter int Weight_BitSize = DefWeightBitSize
) (
    input  logic                             clk,
    input  logic                             res_n,
    input  logic                             i_load,
    input  logic signed [Weight_BitSize-1:0] i_weight,
    input  logic                             i_valid,
    input  logic signed [BitSize-1:0]        i_data,
    input  logic signed [BitSize-1:0]        i_psum,
    output logic signed [Weight_BitSize-1:0] o_weight,
    output logic                             o_valid,
    output logic signed [BitSize-1:0]        o_data,
    output logic signed [BitSize-1:0]        o_psum
);

    logic signed [Weight_BitSize-1:0] r_weight;
    logic signed [BitSize-1:0]        r_data;
    logic signed [BitSize-1:0]        r_psum;
    logic                             r_valid;
    logic signed [BitSize-1:0]        w_weight_ext;
    logic signed [BitSize-1:0]        w_prod;

    assign w_weight_ext = {{(BitSize-Weight_BitSize){r_weight[Weight_BitSize-1]}}, r_weight};
    assign w_prod       = i_data * w_weight_ext;

    // Data and psum only advance with a valid vector, so idle cycles leave results intact.
    always_ff @(posedge clk) begin
        if (res_n) begin
            r_weight <= '0;
            r_data   <= '0;
            r_psum   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_load)
                r_weight <= i_weight;
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_psum <= i_psum + w_prod;
            end
        end
    end

    assign o_weight = r_weight;
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_psum   = r_psum;

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary MAC grid: psum bias skew in, PE grid, output deskew
// so all columns emerge together, and the batch done counter.
module systolic_array_ws
    import systolic_array_ws_pkg::*;
#(
    parameter int BitSize        = DefBitSize,
    parameter int Weight_BitSize = DefWeightBitSize,
    parameter int M_W_BitSize    = DefMWBitSize,
    parameter int NumOfInputs    = DefNumOfInputs,
    parameter int NumOfNerves    = DefNumOfNerves,
    parameter int DepthIn        = DefDepthIn
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  in_valid,
    input  logic                                  in_start,
    input  logic [NumOfInputs*BitSize-1:0]        in_data,
    input  logic [NumOfNerves*M_W_BitSize-1:0]    in_weights,
    input  logic [NumOfNerves*BitSize-1:0]        in_partial_sum,
    input  logic                                  en_l_b,
    output logic                                  out_valid,
    output logic                                  out_done,
    output logic [NumOfNerves-1:0][BitSize-1:0]   out_data
);

    localparam int PipeLatency = calcLatency(NumOfInputs, NumOfNerves);
    localparam int CntW        = $clog2(DepthIn + 1);

    logic                                                 w_in_valid;
    logic [NumOfInputs-1:0]                               w_lane_valid;
    logic [NumOfInputs-2:0]                               r_lane_sr;
    logic [NumOfNerves-1:0][BitSize-1:0]                  w_bias;
    logic [NumOfInputs-1:0][NumOfNerves:0][BitSize-1:0]   w_data_h;
    logic [NumOfInputs-1:0][NumOfNerves:0]                w_valid_h;
    logic [NumOfInputs:0][NumOfNerves-1:0][BitSize-1:0]   w_psum_v;
    logic [NumOfInputs:0][NumOfNerves-1:0][Weight_BitSize-1:0] w_weight_v;
    logic [NumOfNerves-1:0]                               w_col_valid;
    logic [PipeLatency-1:0]                               r_start_sr;
    logic                                                 w_start_out;
    logic [CntW-1:0]                                      r_cnt;
    logic [CntW-1:0]                                      w_cnt_next;
    logic                                                 w_unused;

    assign w_in_valid   = in_valid & ~en_l_b;
    assign w_lane_valid = {r_lane_sr, w_in_valid};

    // Lane r data arrives r cycles after lane 0, so its valid is delayed to match.
    always_ff @(posedge clk) begin
        if (res_n)
            r_lane_sr <= '0;
        else
            r_lane_sr <= w_lane_valid[NumOfInputs-2:0];
    end

    for (genvar c = 0; c < NumOfNerves; c++) begin : g_skew
        if (c == 0) begin : g_direct
            assign w_bias[c] = in_partial_sum[c*BitSize +: BitSize];
        end else begin : g_dly
            logic [c-1:0][BitSize-1:0] r_sk;
            always_ff @(posedge clk) begin
                if (res_n) begin
                    r_sk <= '0;
                end else begin
                    r_sk[0] <= in_partial_sum[c*BitSize +: BitSize];
                    for (int k = 1; k < c; k++)
                        r_sk[k] <= r_sk[k-1];
                end
            end
            assign w_bias[c] = r_sk[c-1];
        end
        assign w_psum_v[0][c]   = w_bias[c];
        assign w_weight_v[0][c] = in_weights[c*M_W_BitSize +: Weight_BitSize];
    end

    for (genvar r = 0; r < NumOfInputs; r++) begin : g_row
        assign w_data_h[r][0]  = in_data[r*BitSize +: BitSize];
        assign w_valid_h[r][0] = w_lane_valid[r];
        for (genvar c = 0; c < NumOfNerves; c++) begin : g_col
            systolic_pe #(
                .BitSize        (BitSize),
                .Weight_BitSize (Weight_BitSize)
            ) u_pe (
                .clk      (clk),
                .res_n    (res_n),
                .i_load   (en_l_b),
                .i_weight (w_weight_v[r][c]),
                .i_valid  (w_valid_h[r][c]),
                .i_data   (w_data_h[r][c]),
                .i_psum   (w_psum_v[r][c]),
                .o_weight (w_weight_v[r+1][c]),
                .o_valid  (w_valid_h[r][c+1]),
                .o_data   (w_data_h[r][c+1]),
                .o_psum   (w_psum_v[r+1][c])
            );
        end
    end

    // Earlier columns finish sooner; each waits NumOfNerves-1-c enabled stages to line up.
    for (genvar c = 0; c < NumOfNerves; c++) begin : g_deskew
        localparam int L = NumOfNerves - 1 - c;
        if (L == 0) begin : g_direct
            assign out_data[c]    = w_psum_v[NumOfInputs][c];
            assign w_col_valid[c] = w_valid_h[NumOfInputs-1][c+1];
        end else begin : g_dly
            logic [L-1:0][BitSize-1:0] r_dd;
            logic [L-1:0]              r_dv;
            always_ff @(posedge clk) begin
                if (res_n) begin
                    r_dd <= '0;
                    r_dv <= '0;
                end else begin
                    r_dv[0] <= w_valid_h[NumOfInputs-1][c+1];
                    if (w_valid_h[NumOfInputs-1][c+1])
                        r_dd[0] <= w_psum_v[NumOfInputs][c];
                    for (int k = 1; k < L; k++) begin
                        r_dv[k] <= r_dv[k-1];
                        if (r_dv[k-1])
                            r_dd[k] <= r_dd[k-1];
                    end
                end
            end
            assign out_data[c]    = r_dd[L-1];
            assign w_col_valid[c] = r_dv[L-1];
        end
    end

    assign out_valid = w_col_valid[NumOfNerves-1];

    always_ff @(posedge clk) begin
        if (res_n)
            r_start_sr <= '0;
        else
            r_start_sr <= {r_start_sr[PipeLatency-2:0], w_in_valid & in_start};
    end

    assign w_start_out = r_start_sr[PipeLatency-1];
    assign w_cnt_next  = w_start_out ? CntW'(1) : r_cnt + CntW'(1);
    assign out_done    = out_valid & (w_cnt_next == CntW'(DepthIn));

    always_ff @(posedge clk) begin
        if (res_n)
            r_cnt <= '0;
        else if (out_valid)
            r_cnt <= out_done ? '0 : w_cnt_next;
    end

    // Edge-of-grid outputs (last column data, bottom-row weights, upper weight bits) go nowhere.
    assign w_unused = ^{in_weights, w_data_h, w_valid_h, w_weight_v, w_col_valid};

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws: hand-computed vectors checked with
// immediate assertions at fixed latency points.
module tb_systolic_array_ws;

    logic              clk = 1'b0;
    logic              res_n;
    logic              in_valid;
    logic              in_start;
    logic [15:0]       in_data;
    logic [23:0]       in_weights;
    logic [23:0]       in_partial_sum;
    logic              en_l_b;
    logic              out_valid;
    logic              out_done;
    logic [2:0][7:0]   out_data;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] lastData;

    always #5 clk = ~clk;

    systolic_array_ws dut (
        .clk            (clk),
        .res_n          (res_n),
        .in_valid       (in_valid),
        .in_start       (in_start),
        .in_data        (in_data),
        .in_weights     (in_weights),
        .in_partial_sum (in_partial_sum),
        .en_l_b         (en_l_b),
        .out_valid      (out_valid),
        .out_done       (out_done),
        .out_data       (out_data)
    );

    function automatic logic [23:0] pack3(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic expDone,
                               input logic [23:0] expData);
        total++;
        assert (out_valid === expValid) else begin
            bad++;
            $error("[TB] FAIL %s out_valid: got %b want %b", tag, out_valid, expValid);
        end
        total++;
        assert (out_done === expDone) else begin
            bad++;
            $error("[TB] FAIL %s out_done: got %b want %b", tag, out_done, expDone);
        end
        total++;
        assert (out_data === expData) else begin
            bad++;
            $error("[TB] FAIL %s out_data: got %h want %h", tag, out_data, expData);
        end
    endtask

    task automatic loadWeights(input logic [23:0] first, input logic [23:0] second);
        en_l_b     = 1'b1;
        in_weights = first;
        tick();
        in_weights = second;
        tick();
        en_l_b     = 1'b0;
        in_weights = '0;
    endtask

    // Lane 0 at cycle t, lane 1 held into t+1; returns at cycle t+2.
    task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] x1,
                                 input logic [7:0] bias, input logic start);
        in_valid       = 1'b1;
        in_start       = start;
        in_data        = {x1, x0};
        in_partial_sum = {bias, bias, bias};
        tick();
        in_valid       = 1'b0;
        in_start       = 1'b0;
        in_partial_sum = '0;
        tick();
    endtask

    task automatic runVector(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                             input logic [7:0] bias, input logic [23:0] expData);
        applyStimulus(x0, x1, bias, 1'b1);
        tick();
        checkOutput({tag, " early"}, 1'b0, 1'b0, lastData);
        tick();
        checkOutput(tag, 1'b1, 1'b0, expData);
        lastData = expData;
        tick();
        checkOutput({tag, " hold"}, 1'b0, 1'b0, lastData);
    endtask

    initial begin
        res_n          = 1'b1;
        in_valid       = 1'b0;
        in_start       = 1'b0;
        in_data        = '0;
        in_weights     = '0;
        in_partial_sum = '0;
        en_l_b         = 1'b0;
        lastData       = '0;
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b0, 24'h0);
        res_n = 1'b0;
        tick();

        loadWeights(pack3(8'd1, 8'd1, 8'd1), pack3(8'd1, 8'd0, 8'd1));
        runVector("basic", 8'd7, 8'd6, 8'd0, pack3(8'd13, 8'd6, 8'd13));
        runVector("bias", 8'd7, 8'd6, 8'd5, pack3(8'd18, 8'd11, 8'd18));

        loadWeights(pack3(8'd0, 8'd0, 8'd0), pack3(8'h03, 8'h03, 8'h03));
        runVector("negw", 8'd7, 8'd9, 8'd0, pack3(8'hF9, 8'hF9, 8'hF9));

        loadWeights(pack3(8'd1, 8'd1, 8'd1), pack3(8'd1, 8'd1, 8'd1));
        runVector("wrap", 8'd100, 8'd100, 8'd0, pack3(8'hC8, 8'hC8, 8'hC8));

        in_valid       = 1'b1;
        in_start       = 1'b1;
        in_data        = {8'd2, 8'd1};
        in_partial_sum = '0;
        tick();
        in_start = 1'b0;
        in_data  = {8'd2, 8'd3};
        tick();
        in_valid = 1'b0;
        in_data  = {8'd4, 8'd3};
        tick();
        checkOutput("batch early", 1'b0, 1'b0, lastData);
        tick();
        checkOutput("batch first", 1'b1, 1'b0, pack3(8'd3, 8'd3, 8'd3));
        tick();
        checkOutput("batch last", 1'b1, 1'b1, pack3(8'd7, 8'd7, 8'd7));
        lastData = pack3(8'd7, 8'd7, 8'd7);
        tick();
        checkOutput("batch hold", 1'b0, 1'b0, lastData);

        in_valid = 1'b1;
        in_start = 1'b1;
        in_data  = {8'd5, 8'd5};
        tick();
        in_valid = 1'b0;
        in_start = 1'b0;
        res_n    = 1'b1;
        tick();
        res_n    = 1'b0;
        lastData = '0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("midreset", 1'b0, 1'b0, 24'h0);
            tick();
        end

        runVector("clearedw", 8'd50, 8'd50, 8'd3, pack3(8'd3, 8'd3, 8'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
